// File: rtl/sbtel_pkg.sv
// rtl/sbtel_pkg.sv - shared types for the execute/writeback boundary
// Contents: EX_WB result record, REG_RSP index, per-entry hazard tag,
//           stage state enum, tag_hits() hazard helper.
package sbtel_pkg;

  localparam logic [3:0] REG_RSP = 4'd4;

  typedef struct packed {
    logic [31:0] value;
    logic [15:0] pc;
    logic        sim_end;
  } EX_WB;

  // Register-write footprint of one buffered result, kept beside the record
  // so the hazard scoreboard never has to look at the payload.
  typedef struct packed {
    logic [3:0] dest;
    logic       dest_we;
    logic       rsp_we;
  } exwb_tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } stage_state_e;

  // PUSH/POP/CALL/RET touch RSP without naming it as dest.
  function automatic logic tag_hits(exwb_tag_t t, logic [3:0] r);
    return (t.dest_we && (t.dest == r)) || (t.rsp_we && (r == REG_RSP));
  endfunction

endpackage

// File: rtl/mod_exwb_stage_if.sv
// rtl/mod_exwb_stage_if.sv - EX->WB handshake bundle
// master: execute/writeback side (drives results and wb_ready)
// slave:  mod_exwb_stage (drives ex_ready, can_writeback, exwb)
interface mod_exwb_stage_if;
  import sbtel_pkg::*;

  logic       ex_valid;
  logic       ex_ready;
  EX_WB       exwb_in;
  logic [3:0] ex_dest;
  logic       ex_dest_we;
  logic       ex_rsp_we;
  logic       wb_ready;
  logic       can_writeback;
  EX_WB       exwb;

  modport master (
    output ex_valid, exwb_in, ex_dest, ex_dest_we, ex_rsp_we, wb_ready,
    input  ex_ready, can_writeback, exwb
  );

  modport slave (
    input  ex_valid, exwb_in, ex_dest, ex_dest_we, ex_rsp_we, wb_ready,
    output ex_ready, can_writeback, exwb
  );

endinterface

// File: rtl/mod_exwb_fifo.sv
// rtl/mod_exwb_fifo.sv - EX->WB result buffer storage and pointers
// Ports: clk, reset_n (async, active low); push/pop/flush strobes;
//        push_rec/push_tag write data; head_valid/head_rec read side;
//        count, per-entry valid bits and tags for the hazard scoreboard.
module mod_exwb_fifo
  import sbtel_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  EX_WB                    push_rec,
  input  exwb_tag_t               push_tag,
  output logic                    head_valid,
  output EX_WB                    head_rec,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0]        valid,
  output exwb_tag_t [DEPTH-1:0]   tags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  EX_WB                   recs [DEPTH];
  exwb_tag_t [DEPTH-1:0]  tag_q;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Control state; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      // Push and pop never target the same slot: the stage refuses pushes
      // when full and pop needs a valid head.
      if (pop)  valid[rd_ptr] <= 1'b0;
      if (push) valid[wr_ptr] <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      recs[wr_ptr]  <= push_rec;
      tag_q[wr_ptr] <= push_tag;
    end
  end

  assign head_valid = valid[rd_ptr];
  assign head_rec   = recs[rd_ptr];
  assign tags       = tag_q;

endmodule

// File: rtl/mod_exwb_stage.sv
// rtl/mod_exwb_stage.sv - EX->WB buffer stage with hazard scoreboard
// Ports: clk, reset_n (async, active low); exwb_bus (slave) carries the
//        execute handshake, result record and writeback handshake;
//        flush; rd_reg_a/rd_reg_b decode queries -> dep_exwb[1:0];
//        retired (64-bit pop count); sim_done (sim_end entry consumed).
module mod_exwb_stage
  import sbtel_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREGS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mod_exwb_stage_if.slave         exwb_bus,
  input  logic                    flush,
  input  logic [3:0]              rd_reg_a,
  input  logic [3:0]              rd_reg_b,
  output logic [1:0]              dep_exwb,
  output logic [63:0]             retired,
  output logic                    sim_done
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]          count;
  logic [DEPTH-1:0]       valid;
  exwb_tag_t [DEPTH-1:0]  tags;
  exwb_tag_t              push_tag;
  EX_WB                   head_rec;
  logic                   head_valid;
  logic                   push;
  logic                   pop;
  logic                   accept;
  stage_state_e           state;
  stage_state_e           state_nx;

  assign push     = exwb_bus.ex_valid && accept;
  assign pop      = head_valid && exwb_bus.wb_ready;
  assign push_tag = '{dest: exwb_bus.ex_dest, dest_we: exwb_bus.ex_dest_we,
                      rsp_we: exwb_bus.ex_rsp_we};

  mod_exwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_rec   (exwb_bus.exwb_in),
    .push_tag   (push_tag),
    .head_valid (head_valid),
    .head_rec   (head_rec),
    .count      (count),
    .valid      (valid),
    .tags       (tags)
  );

  assign exwb_bus.ex_ready      = accept;
  assign exwb_bus.can_writeback = head_valid;
  assign exwb_bus.exwb          = head_valid ? head_rec : '0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  // Next state. In DRAIN the sim_end entry is the youngest, so the pop that
  // carries sim_end is the last one.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (push && exwb_bus.exwb_in.sim_end) state_nx = DRAIN;
      DRAIN: begin
        if (flush)                          state_nx = RUN;
        else if (pop && head_rec.sim_end)   state_nx = DONE;
      end
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  // Outputs; ex_ready deliberately ignores wb_ready.
  always_comb begin
    accept   = 1'b0;
    sim_done = 1'b0;
    case (state)
      RUN:     accept   = (count < CW'(DEPTH)) && !flush;
      DONE:    sim_done = 1'b1;
      default: accept   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          retired <= '0;
    else if (pop && !flush) retired <= retired + 64'd1;
  end

  // Hazard scoreboard; an entry leaving this cycle is still in valid.
  // Indices outside the architectural file can never be written.
  always_comb begin
    dep_exwb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        if (tag_hits(tags[i], rd_reg_a)) dep_exwb[0] = 1'b1;
        if (tag_hits(tags[i], rd_reg_b)) dep_exwb[1] = 1'b1;
      end
    end
    if ({1'b0, rd_reg_a} >= 5'(NREGS)) dep_exwb[0] = 1'b0;
    if ({1'b0, rd_reg_b} >= 5'(NREGS)) dep_exwb[1] = 1'b0;
  end

endmodule

// File: doc/mod_exwb_stage.md
MOD_EXWB_STAGE -- requirements
Module: mod_exwb_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; port names follow below.
REQ-002 The block SHALL use parameter DEPTH, default 2, as the EX->WB buffer depth in entries.
REQ-003 The block SHALL use parameter NREGS, default 16, as the architectural register count.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port ex_valid, input, 1 bit: the execute stage presents a result.
REQ-007 The block SHALL have port ex_ready, output, 1 bit: the stage can accept the result this cycle.
REQ-008 The block SHALL have port exwb_in, input, EX_WB: result record from execute.
REQ-009 The block SHALL have port ex_dest, input, 4 bits: destination GPR index of that result.
REQ-010 The block SHALL have port ex_dest_we, input, 1 bit: the result writes ex_dest.
REQ-011 The block SHALL have port ex_rsp_we, input, 1 bit: the result modifies RSP (reg 4), i.e. PUSH/POP/CALL/RET.
REQ-012 The block SHALL have port wb_ready, input, 1 bit: writeback consumes the head this cycle.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all buffered results.
REQ-014 The block SHALL have port rd_reg_a and rd_reg_b, inputs, 4 bits each: source registers queried by decode.
REQ-015 The block SHALL have port can_writeback, output, 1 bit: head entry valid.
REQ-016 The block SHALL have port exwb, output, EX_WB: head entry record.
REQ-017 The block SHALL have port dep_exwb, output, 2 bits: [0] rd_reg_a hazard, [1] rd_reg_b hazard.
REQ-018 The block SHALL have port retired, output, 64 bits: count of entries consumed by writeback.
REQ-019 The block SHALL have port sim_done, output, 1 bit: the sim_end entry has been consumed.

Function
REQ-020 Push SHALL occur on the rising edge when ex_valid && ex_ready; pop SHALL occur on the rising edge when can_writeback && wb_ready.
REQ-021 ex_ready SHALL be (count < DEPTH) && state==RUN && !flush, and SHALL not depend on wb_ready (no full-buffer pass-through).
REQ-022 Latency SHALL be one cycle: an entry pushed at edge N SHALL be visible on exwb/can_writeback after edge N when the buffer was empty.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-025 When can_writeback=0, exwb SHALL be all zeros.
REQ-026 dep_exwb[i] SHALL be 1 iff some valid entry has dest_we with dest==rd_reg_i, or some valid entry has rsp_we and rd_reg_i==4; this is combinational, and an entry being popped this cycle still counts.
REQ-027 The state machine SHALL have states RUN, DRAIN and DONE: RUN->DRAIN on a push with exwb_in.sim_end=1; DRAIN->DONE on a pop of that entry; DONE is held until reset.
REQ-028 In DRAIN and DONE, ex_ready SHALL be 0; sim_done SHALL be 1 only in DONE.
REQ-029 Flush SHALL clear count, pointers and all valid bits at the next edge, and SHALL override a same-cycle push and pop (retired is not incremented).
REQ-030 Flush SHALL move DRAIN->RUN, and SHALL have no effect in DONE.
REQ-031 retired SHALL increment by 1 per pop and wrap at 2^64.

Reset
REQ-032 While reset_n=0, state SHALL be RUN, count, pointers and retired SHALL be 0, and all entries SHALL be invalid.
REQ-033 Consequently during reset can_writeback=0, exwb=0, dep_exwb=0, sim_done=0, and ex_ready=1 after reset release.
REQ-034 Reset asserted mid-operation SHALL discard buffered entries immediately, with no pop reported.

Structure
REQ-035 The EX_WB typedef, a REG_RSP=4 constant and the state enum SHALL reside in shared package sbtel_pkg, also imported by mod_writeback.
REQ-036 Buffer storage and pointers SHALL be the sub-module mod_exwb_fifo (parameterised DEPTH); the FSM, scoreboard and counter stay in mod_exwb_stage.

Verification
REQ-037 The bench SHALL push 3 records back-to-back with wb_ready=0 and check ex_ready drops after 2 pushes and the 3rd is held; then raise wb_ready and check order is preserved and retired=3.
REQ-038 The bench SHALL hold ex_dest=5, ex_dest_we=1 in the buffer with rd_reg_a=5, rd_reg_b=4 and check dep_exwb=2'b01; after pushing a record with ex_rsp_we=1, check dep_exwb=2'b11.
REQ-039 The bench SHALL push and pop simultaneously at count=1 for 10 cycles and check count stays 1 and retired=10.
REQ-040 The bench SHALL push a record with sim_end=1 followed by another push attempt, check ex_ready=0, then pop and check sim_done=1 and that the state persists until reset.
REQ-041 The bench SHALL assert flush with count=2 and a push and pop in the same cycle, and check count=0, retired unchanged and dep_exwb=0 on the next cycle.
REQ-042 The bench SHALL drop reset_n asynchronously mid-cycle with count=2 and check can_writeback=0 immediately.
